// File: rtl/ram_responder.sv
// Word-addressed RAM model answering the memory controller's RAM port with a
// programmable access latency; reports FREE/BUSY/ACCESS/ERROR.

package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int    LAT       = 2,
    parameter int    ADDR_W    = 14,
    parameter string INIT_FILE = ""
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

    // Contents start zeroed and survive nRST; only a completed ACCESS writes.
    word_t mem [DEPTH] = '{default: '0};

    logic              active;
    logic [CNT_W-1:0]  cnt;
    word_t             lat_addr;
    logic              lat_wen;

    logic              req;
    logic              err;
    logic              match;
    logic [CNT_W-1:0]  cnt_eff;
    logic [ADDR_W-1:0] idx;

    assign req   = ramREN ^ ramWEN;
    assign err   = (ramREN & ramWEN)
                 | (req & ((ramaddr[1:0] != 2'b00) || (ramaddr[31:ADDR_W+2] != '0)));
    assign idx   = ramaddr[ADDR_W+1:2];

    // A request only keeps its progress while address and direction stay put.
    assign match   = active && (lat_addr == ramaddr) && (lat_wen == ramWEN);
    assign cnt_eff = match ? cnt : '0;

    always_comb begin
        ramstate = BUSY;
        if (err)
            ramstate = ERROR;
        else if (!req)
            ramstate = FREE;
        else if (cnt_eff == LAT_C)
            ramstate = ACCESS;
    end

    always_comb begin
        ramload = '0;
        if (ramstate == ACCESS && ramREN)
            ramload = mem[idx];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            active   <= 1'b0;
            cnt      <= '0;
            lat_addr <= '0;
            lat_wen  <= 1'b0;
        end else begin
            case (ramstate)
                BUSY: begin
                    active   <= 1'b1;
                    lat_addr <= ramaddr;
                    lat_wen  <= ramWEN;
                    cnt      <= cnt_eff + CNT_W'(1);
                end
                default: begin
                    active <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Gated by nRST so a reset landing on the ACCESS edge never commits a write.
    always_ff @(posedge CLK) begin
        if (nRST && ramstate == ACCESS && ramWEN)
            mem[idx] <= ramstore;
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one LAT=2 instance and one LAT=0 instance.

module tb_ram_responder;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      nRST;

    logic      ren2, wen2;
    word_t     addr2, store2, load2;
    ramstate_t st2;

    logic      ren0, wen0;
    word_t     addr0, store0, load0;
    ramstate_t st0;

    int totalChecks;
    int passedChecks;

    ram_responder #(.LAT(2), .ADDR_W(14), .INIT_FILE("")) dut2 (
        .CLK(CLK), .nRST(nRST),
        .ramREN(ren2), .ramWEN(wen2), .ramaddr(addr2), .ramstore(store2),
        .ramload(load2), .ramstate(st2)
    );

    ram_responder #(.LAT(0), .ADDR_W(14), .INIT_FILE("")) dut0 (
        .CLK(CLK), .nRST(nRST),
        .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0), .ramstore(store0),
        .ramload(load0), .ramstate(st0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic rstn, input logic ren, input logic wen,
                                 input word_t addr, input word_t data);
        @(posedge CLK);
        #1;
        nRST   = rstn;
        ren2   = ren;
        wen2   = wen;
        addr2  = addr;
        store2 = data;
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input ramstate_t obsSt, input word_t obsLd,
                               input ramstate_t expSt, input word_t expLd);
        totalChecks++;
        assert (obsSt === expSt && obsLd === expLd) begin
            passedChecks++;
        end else begin
            $error("[TB] FAIL %s: got state=%0d load=%h, expected state=%0d load=%h",
                   tag, obsSt, obsLd, expSt, expLd);
        end
    endtask

    // Full LAT=2 transaction held stable: BUSY, BUSY, ACCESS.
    task automatic expectLatency(input string tag, input logic ren, input logic wen,
                                 input word_t addr, input word_t data, input word_t expLd);
        applyStimulus(1'b1, ren, wen, addr, data);
        checkOutput({tag, "_b0"}, st2, load2, BUSY, 32'h0);
        applyStimulus(1'b1, ren, wen, addr, data);
        checkOutput({tag, "_b1"}, st2, load2, BUSY, 32'h0);
        applyStimulus(1'b1, ren, wen, addr, data);
        checkOutput({tag, "_acc"}, st2, load2, ACCESS, expLd);
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput(tag, st2, load2, FREE, 32'h0);
    endtask

    initial begin
        totalChecks  = 0;
        passedChecks = 0;
        nRST   = 1'b0;
        ren2   = 1'b0; wen2 = 1'b0; addr2 = '0; store2 = '0;
        ren0   = 1'b0; wen0 = 1'b0; addr0 = '0; store0 = '0;

        // Reset behaviour
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("reset_idle", st2, load2, FREE, 32'h0);
        checkOutput("reset_idle_lat0", st0, load0, FREE, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("reset_held_req", st2, load2, BUSY, 32'h0);
        idle("after_reset");

        // Write then read back the same word
        expectLatency("wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
        expectLatency("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        idle("free1");

        // Held read: ACCESS every LAT+1 cycles
        expectLatency("rd80_first", 1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
        expectLatency("rd80_second", 1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
        idle("free2");

        // Request dropped mid-wait clears the counter
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        checkOutput("drop_busy", st2, load2, BUSY, 32'h0);
        idle("drop_free");
        expectLatency("drop_restart", 1'b1, 1'b0, 32'h80, 32'h0, 32'h0);

        // Address change mid-wait restarts counting
        expectLatency("wr44", 1'b0, 1'b1, 32'h44, 32'h11111111, 32'h0);
        idle("free3");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("addr_change_first", st2, load2, BUSY, 32'h0);
        expectLatency("addr_change_44", 1'b1, 1'b0, 32'h44, 32'h0, 32'h11111111);

        // Direction flip restarts counting; aborted write leaves no trace
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h48, 32'h55555555);
        checkOutput("flip_wr", st2, load2, BUSY, 32'h0);
        expectLatency("flip_rd48", 1'b1, 1'b0, 32'h48, 32'h0, 32'h0);
        idle("free4");

        // Error conditions, then confirm memory untouched
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h0BAD0BAD);
        checkOutput("err_both", st2, load2, ERROR, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h42, 32'h0);
        checkOutput("err_misaligned", st2, load2, ERROR, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00010000, 32'h0BAD0BAD);
        checkOutput("err_range", st2, load2, ERROR, 32'h0);
        expectLatency("err_chk40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        expectLatency("err_chk0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        idle("free5");

        // Reset on the second BUSY cycle of a held read
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("rst_busy0", st2, load2, BUSY, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("rst_busy1", st2, load2, BUSY, 32'h0);
        expectLatency("rst_release", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        idle("free6");

        // Reset during the ACCESS cycle of a write suppresses the commit
        expectLatency("wr60_old", 1'b0, 1'b1, 32'h60, 32'hAAAAAAAA, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h60, 32'h12345678);
        checkOutput("wr60_b0", st2, load2, BUSY, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h60, 32'h12345678);
        checkOutput("wr60_b1", st2, load2, BUSY, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h60, 32'h12345678);
        checkOutput("wr60_rst_access", st2, load2, BUSY, 32'h0);
        idle("free7");
        expectLatency("rd60", 1'b1, 1'b0, 32'h60, 32'h0, 32'hAAAAAAAA);
        idle("free8");

        // Zero-latency instance
        @(posedge CLK);
        #1;
        ren0 = 1'b0; wen0 = 1'b1; addr0 = 32'h100; store0 = 32'hCAFEF00D;
        @(negedge CLK);
        checkOutput("lat0_wr", st0, load0, ACCESS, 32'h0);
        @(posedge CLK);
        #1;
        ren0 = 1'b1; wen0 = 1'b0; addr0 = 32'h100; store0 = 32'h0;
        @(negedge CLK);
        checkOutput("lat0_rd", st0, load0, ACCESS, 32'hCAFEF00D);
        @(posedge CLK);
        #1;
        ren0 = 1'b0;
        @(negedge CLK);
        checkOutput("lat0_free", st0, load0, FREE, 32'h0);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
